// File: rtl/adc_iq_capture.sv
// Dual 10-bit ADC front end: registers I/Q, converts offset-binary to two's complement and
// captures armed frames into a first-word-fall-through FIFO. Macro OTR_SATURATE_EN saturates over-range samples.
module adc_iq_capture #(
  parameter int FRAME_LEN  = 4096,
  parameter int FIFO_DEPTH = 16,
  parameter int SETTLE_CYC = 4
) (
  input  logic       clk_rom,
  input  logic       rst_n,
  input  logic [9:0] ad1_data,
  input  logic       ad1_otr,
  input  logic [9:0] ad2_data,
  input  logic       ad2_otr,
  input  logic       arm,
  output logic       ad_oe_n,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [9:0] m_i,
  output logic [9:0] m_q,
  output logic       m_last,
  output logic       busy,
  output logic       done,
  output logic [1:0] otr_sticky,
  output logic       drop_sticky
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [15:0] FRAME_LAST  = 16'(FRAME_LEN - 1);
  localparam logic [AW:0] CNT_FULL    = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0] CNT_ONE     = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  function automatic logic [9:0] to_twos(input logic [9:0] raw);
    return {~raw[9], raw[8:0]};
  endfunction

  logic [9:0]  ad1_q, ad2_q;
  logic        ad1_otr_q, ad2_otr_q;
  logic [1:0]  state_q, state_d;
  logic [7:0]  settle_q, settle_d;
  logic [15:0] samp_q, samp_d;
  logic [1:0]  otr_q, otr_d;
  logic        drop_q, drop_d;
  logic        ad_oe_n_q, ad_oe_n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        m_valid_q, m_valid_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [20:0]   fifo_q [FIFO_DEPTH];
  logic          capture, full, pop, push, drop;
  logic [9:0]    i_conv, q_conv;

  assign capture = (state_q == ST_CAPTURE);
  assign full    = (count_q == CNT_FULL);
  assign pop     = m_valid_q && m_ready;
  // A pop in the same cycle frees the slot, so a full FIFO only drops without one.
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  // Sample conversion, with optional saturation of over-range channels.
  always_comb begin
    i_conv = to_twos(ad1_q);
    q_conv = to_twos(ad2_q);
`ifdef OTR_SATURATE_EN
    if (ad1_otr_q) i_conv = ad1_q[9] ? 10'h1FF : 10'h200;
    if (ad2_otr_q) q_conv = ad2_q[9] ? 10'h1FF : 10'h200;
`endif
  end

  // Frame sequencing and sticky status.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    samp_d   = samp_q;
    otr_d    = otr_q;
    drop_d   = drop_q;
    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          otr_d    = 2'b00;
          drop_d   = 1'b0;
          settle_d = 8'd0;
          samp_d   = 16'd0;
          state_d  = (SETTLE_CYC == 0) ? ST_CAPTURE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = ST_CAPTURE;
        else settle_d = settle_q + 8'd1;
      end
      ST_CAPTURE: begin
        otr_d = otr_q | {ad2_otr_q, ad1_otr_q};
        if (drop) drop_d = 1'b1;
        if (samp_q == FRAME_LAST) state_d = ST_DONE;
        else samp_d = samp_q + 16'd1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ad_oe_n_d = !((state_d == ST_SETTLE) || (state_d == ST_CAPTURE));
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
  end

  // FIFO pointers and occupancy.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    if (push && !pop) count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;
    else count_d = count_q;
    m_valid_d = (count_d != '0);
  end

  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      ad1_q <= 10'd0; ad2_q <= 10'd0; ad1_otr_q <= 1'b0; ad2_otr_q <= 1'b0;
      state_q <= ST_IDLE; settle_q <= 8'd0; samp_q <= 16'd0;
      otr_q <= 2'b00; drop_q <= 1'b0;
      ad_oe_n_q <= 1'b1; busy_q <= 1'b0; done_q <= 1'b0; m_valid_q <= 1'b0;
      wr_ptr_q <= '0; rd_ptr_q <= '0; count_q <= '0;
    end else begin
      ad1_q <= ad1_data; ad2_q <= ad2_data; ad1_otr_q <= ad1_otr; ad2_otr_q <= ad2_otr;
      state_q <= state_d; settle_q <= settle_d; samp_q <= samp_d;
      otr_q <= otr_d; drop_q <= drop_d;
      ad_oe_n_q <= ad_oe_n_d; busy_q <= busy_d; done_q <= done_d; m_valid_q <= m_valid_d;
      wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; count_q <= count_d;
    end
  end

  // Storage is cleared on reset so the head reads zero until the first write.
  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < FIFO_DEPTH; k++) fifo_q[k] <= 21'd0;
    end else if (push) begin
      fifo_q[wr_ptr_q] <= {samp_q == FRAME_LAST, i_conv, q_conv};
    end
  end

  assign ad_oe_n     = ad_oe_n_q;
  assign m_valid     = m_valid_q;
  assign m_last      = fifo_q[rd_ptr_q][20];
  assign m_i         = fifo_q[rd_ptr_q][19:10];
  assign m_q         = fifo_q[rd_ptr_q][9:0];
  assign busy        = busy_q;
  assign done        = done_q;
  assign otr_sticky  = otr_q;
  assign drop_sticky = drop_q;
endmodule

// File: doc/adc_iq_capture.md
Name: adc_iq_capture

Overview:
- Receive-side front end for the dual 10-bit ADC interface (AD1 = I, AD2 = Q) that the demodulator consumes.
- Runs on the ADC sample clock. Drives the shared ADC output enable, registers both channels and converts offset-binary to two's complement.
- Captures armed frames of FRAME_LEN I/Q pairs into a first-word-fall-through FIFO, read out over a valid/ready stream to the demodulation datapath.

Parameters:
- FRAME_LEN, 4096, I/Q pairs captured per arm; range 1..65535.
- FIFO_DEPTH, 16, FIFO entries; power of two, at least 2.
- SETTLE_CYC, 4, cycles from ad_oe_n falling to the first captured sample; range 0..255.

Ports:
- clk_rom  in  1  ADC sample clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ad1_data  in  10  I-channel sample, offset binary.
- ad1_otr  in  1  I-channel over-range.
- ad2_data  in  10  Q-channel sample, offset binary.
- ad2_otr  in  1  Q-channel over-range.
- arm  in  1  single-cycle request to start one frame capture.
- ad_oe_n  out  1  ADC output enable, active low.
- m_valid  out  1  FIFO head valid.
- m_ready  in  1  downstream accepts the head.
- m_i  out  10  I sample, two's complement.
- m_q  out  10  Q sample, two's complement.
- m_last  out  1  head is the final pair of its frame.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when the frame is complete.
- otr_sticky  out  2  {Q,I} over-range seen during capture; cleared on arm.
- drop_sticky  out  1  at least one pair lost to a full FIFO; cleared on arm.

Behaviour:
- Reset values: ad_oe_n=1, m_valid=0, m_i/m_q=0, m_last=0, busy=0, done=0, otr_sticky=0, drop_sticky=0. FIFO emptied, counters cleared, state IDLE.
- Input stage: ad*_data and ad*_otr are registered every cycle in all states.
- Conversion: signed = {~raw[9], raw[8:0]}. 10'h200 maps to 0, 10'h000 to -512, 10'h3FF to +511.
- States:
  - IDLE: ad_oe_n=1. When arm=1, clear both sticky flags and go to SETTLE.
  - SETTLE: ad_oe_n=0. Count SETTLE_CYC cycles, then go to CAPTURE. If SETTLE_CYC=0, go from IDLE directly to CAPTURE.
  - CAPTURE: ad_oe_n=0. Every cycle push the registered pair into the FIFO. m_last is tagged on the pair with sample count FRAME_LEN-1. OR the registered otr bits into otr_sticky. After FRAME_LEN cycles, go to DONE.
  - DONE: done=1 for one cycle, ad_oe_n=1, next state IDLE.
- arm outside IDLE is ignored.
- Latency: a pair on the pins at edge E is registered at E, written at E+1, and appears at m_i/m_q with m_valid=1 after E+1 when the FIFO was empty.
- Stream handshake:
  - Transfer occurs when m_valid&&m_ready.
  - m_i/m_q/m_last are held stable while m_valid=1 and m_ready=0.
  - m_valid never depends combinationally on m_ready.
- FIFO full during a CAPTURE push: the pair is discarded and drop_sticky is set. The sample counter still advances, so the frame length in time is fixed. If the discarded pair was the last one, no m_last is emitted.
- Simultaneous push and pop on a full FIFO: the pop frees the slot, so the push succeeds with no drop. Push and pop on an empty FIFO: the pushed entry becomes the head and m_valid=1 next cycle.
- Pointers wrap modulo FIFO_DEPTH. The occupancy counter ranges 0..FIFO_DEPTH.
- After a frame ends, FIFO contents keep draining. A new arm may start capture before the FIFO is empty.
- Reset mid-capture: immediate return to reset values; the FIFO is flushed and the partial frame is lost.

Optional Feature:
- Macro OTR_SATURATE_EN.
- Defined: a channel whose registered otr=1 is forced to saturation. If raw[9]=1, output +511 (10'h1FF); otherwise output -512 (10'h200). The sticky flag is still set.
- Undefined: samples pass through the conversion unmodified; otr only affects otr_sticky.

Test Plan:
- Data mapping: after reset, arm with FRAME_LEN=8, SETTLE_CYC=4, m_ready=1, ad1 = ad2 = ramp address 0,1,2,… -> ad_oe_n low 1 cycle after arm. Eight pairs appear with m_i = {~a[9],a[8:0]}. m_last is set on the 8th pair only; done pulses once; ad_oe_n returns to 1.
- Conversion corners: inputs 10'h000, 10'h200, 10'h3FF -> m_i = 10'h200, 10'h000, 10'h1FF.
- Backpressure: FRAME_LEN=32, FIFO_DEPTH=16, m_ready=0 throughout capture -> exactly 16 pairs are kept (samples 0..15), drop_sticky=1, no m_last. Then m_ready=1 -> the 16 pairs drain in order with stable data during stalls.
- Over-range: pulse ad2_otr for 1 cycle mid-capture with ad2_data=10'h3FF -> otr_sticky=2'b10, cleared by the next arm. With OTR_SATURATE_EN, that m_q=10'h1FF.
- Ignored arm and reset: arm pulsed during CAPTURE -> frame length unchanged. rst_n low mid-capture -> all outputs at reset values, m_valid=0. A fresh arm after reset captures normally.
